comm_bus_target: RTL and testbench

- Bus responder for the request interface driven by the comm controller (reqdev/req/req_block/rw/add/data out; ready/done/valid/data back).
- Implements a parameterised on-chip word memory as a target device.
- Supports single-word and block (BLOCK_WORDS) reads and writes, programmable wait states, clear/abort, and address-error exceptions.
- Used as the memory end of the host comm path and as the standalone target for comm controller verification.

---
 rtl/comm_bus_target.sv | 142 ++++++++++++++
 tb/tb_comm_bus_target.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comm_bus_target.sv
// ============================================================================
// Module   : comm_bus_target
// Purpose  : Word-memory bus target with single/block transfers, wait states,
//            clear/abort and address-error exceptions.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module comm_bus_target #(
  parameter logic [2:0] DEV_ID      = 3'd0,
  parameter int         BW_DEPTH    = 10,
  parameter int         BLOCK_WORDS = 4,
  parameter int         LATENCY     = 2
) (
  input  logic        clock_i,
  input  logic        resetn_i,
  input  logic [2:0]  reqdev_i,
  input  logic        req_i,
  input  logic        req_block_i,
  input  logic        rw_i,
  input  logic [26:0] add_i,
  input  logic [31:0] data_i,
  input  logic        clear_i,
  output logic        ready_o,
  output logic        done_o,
  output logic        valid_o,
  output logic [31:0] data_o,
  output logic        exception_o
);

  localparam int c_blk_log = $clog2(BLOCK_WORDS);
  localparam int c_cnt_w   = c_blk_log + 1;
  localparam int c_depth   = 1 << BW_DEPTH;

  localparam logic [BW_DEPTH-1:0] c_blk_mask = BW_DEPTH'(BLOCK_WORDS - 1);
  localparam logic [c_cnt_w-1:0]  c_last_blk = c_cnt_w'(BLOCK_WORDS - 1);
  localparam logic [3:0]          c_wait_init = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_wait = 2'd1;
  localparam logic [1:0] c_st_xfer = 2'd2;
  localparam logic [1:0] c_st_done = 2'd3;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic                r_rw;
  logic                r_block;
  logic [BW_DEPTH-1:0] r_idx;
  logic [BW_DEPTH-1:0] w_idx_nxt;
  logic [BW_DEPTH-1:0] w_idx_inc;
  logic [BW_DEPTH-1:0] w_add_idx;
  logic [BW_DEPTH-1:0] w_add_base;
  logic [c_cnt_w-1:0]  r_beat;
  logic [3:0]          r_wait;
  logic                w_accept;
  logic                w_addr_err;
  logic                w_last;
  logic                w_rd_next;

  logic [31:0] r_mem [0:c_depth-1];

  assign w_accept   = (r_state == c_st_idle) && ready_o && req_i &&
                      (reqdev_i == DEV_ID) && !clear_i;
  assign w_addr_err = (add_i[1:0] != 2'b00) || ((add_i >> (BW_DEPTH + 2)) != 27'd0);
  assign w_add_idx  = add_i[BW_DEPTH+1:2];
  assign w_add_base = req_block_i ? (w_add_idx & ~c_blk_mask) : w_add_idx;

  // Beat index wraps inside the block; upper index bits never change.
  assign w_idx_inc  = (r_idx & ~c_blk_mask) | ((r_idx + BW_DEPTH'(1)) & c_blk_mask);
  assign w_last     = (r_beat == (r_block ? c_last_blk : {c_cnt_w{1'b0}}));

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      c_st_idle: begin
        if (w_accept) begin
          if (w_addr_err) begin
            w_state_nxt = c_st_done;
          end else begin
            w_idx_nxt   = w_add_base;
            w_state_nxt = (LATENCY > 0) ? c_st_wait : c_st_xfer;
          end
        end
      end
      c_st_wait: begin
        if (r_wait == 4'd0) w_state_nxt = c_st_xfer;
      end
      c_st_xfer: begin
        w_idx_nxt = w_idx_inc;
        if (w_last) w_state_nxt = c_st_done;
      end
      default: w_state_nxt = c_st_idle;
    endcase
    if (clear_i && (r_state != c_st_idle)) w_state_nxt = c_st_idle;
  end

  // Read data is fetched at the edge entering each read beat.
  assign w_rd_next = (w_state_nxt == c_st_xfer) &&
                     ((r_state == c_st_idle) ? !rw_i : !r_rw);

  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      r_state     <= c_st_idle;
      r_rw        <= 1'b0;
      r_block     <= 1'b0;
      r_idx       <= '0;
      r_beat      <= '0;
      r_wait      <= 4'd0;
      ready_o     <= 1'b0;
      done_o      <= 1'b0;
      valid_o     <= 1'b0;
      data_o      <= 32'd0;
      exception_o <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      ready_o     <= (w_state_nxt == c_st_idle);
      valid_o     <= (w_state_nxt == c_st_xfer);
      done_o      <= (w_state_nxt == c_st_done);
      exception_o <= w_accept && w_addr_err;
      if (w_accept) begin
        r_rw    <= rw_i;
        r_block <= req_block_i;
        r_beat  <= '0;
        r_wait  <= c_wait_init;
      end else begin
        if ((r_state == c_st_wait) && (r_wait != 4'd0)) r_wait <= r_wait - 4'd1;
        if (r_state == c_st_xfer) r_beat <= r_beat + c_cnt_w'(1);
      end
      if (w_rd_next) data_o <= r_mem[w_idx_nxt];
    end
  end

  // Memory contents survive reset; a write beat commits even when cleared.
  always_ff @(posedge clock_i) begin
    if (resetn_i && (r_state == c_st_xfer) && r_rw) r_mem[r_idx] <= data_i;
  end

endmodule

`default_nettype wire

// File: tb/tb_comm_bus_target.sv
// ============================================================================
// Module   : tb_comm_bus_target
// Purpose  : Directed self-checking bench for comm_bus_target (LATENCY 2 and 0).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_comm_bus_target;

  logic        clk;
  logic        resetn_i;
  logic [2:0]  reqdev_i;
  logic        req_i;
  logic        req_block_i;
  logic        rw_i;
  logic [26:0] add_i;
  logic [31:0] data_i;
  logic        clear_i;

  logic        ready2, done2, valid2, exc2;
  logic [31:0] data2;
  logic        ready0, done0, valid0, exc0;
  logic [31:0] data0;

  int checks;
  int failures;

  logic        cap_v [0:31];
  logic        cap_d [0:31];
  logic        cap_e [0:31];
  logic        cap_r [0:31];
  logic [31:0] cap_data [0:31];
  logic [31:0] cap_rd [0:15];
  logic [31:0] wd [0:15];
  int          nrd;

  comm_bus_target #(.DEV_ID(3'd0), .BW_DEPTH(10), .BLOCK_WORDS(4), .LATENCY(2)) dut2 (
    .clock_i(clk), .resetn_i(resetn_i), .reqdev_i(reqdev_i), .req_i(req_i),
    .req_block_i(req_block_i), .rw_i(rw_i), .add_i(add_i), .data_i(data_i),
    .clear_i(clear_i), .ready_o(ready2), .done_o(done2), .valid_o(valid2),
    .data_o(data2), .exception_o(exc2)
  );

  comm_bus_target #(.DEV_ID(3'd0), .BW_DEPTH(10), .BLOCK_WORDS(4), .LATENCY(0)) dut0 (
    .clock_i(clk), .resetn_i(resetn_i), .reqdev_i(reqdev_i), .req_i(req_i),
    .req_block_i(req_block_i), .rw_i(rw_i), .add_i(add_i), .data_i(data_i),
    .clear_i(clear_i), .ready_o(ready0), .done_o(done0), .valid_o(valid0),
    .data_o(data0), .exception_o(exc0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sample(input int k, input bit use0);
    cap_v[k]    = use0 ? valid0 : valid2;
    cap_d[k]    = use0 ? done0  : done2;
    cap_e[k]    = use0 ? exc0   : exc2;
    cap_r[k]    = use0 ? ready0 : ready2;
    cap_data[k] = use0 ? data0  : data2;
  endtask

  // Issue one request at cycle 0 and record outputs for cycles 0..ncyc.
  task automatic run_txn(input bit use0, input logic rw, input logic blk,
                         input logic [26:0] add, input int ncyc, input int clr_at);
    int nb;
    nb          = 0;
    nrd         = 0;
    reqdev_i    = 3'd0;
    req_i       = 1'b1;
    rw_i        = rw;
    req_block_i = blk;
    add_i       = add;
    data_i      = wd[0];
    clear_i     = 1'b0;
    @(negedge clk);
    sample(0, use0);
    @(posedge clk);
    #1 req_i = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      sample(k, use0);
      if (cap_v[k]) begin
        if (!rw) begin
          cap_rd[nrd] = cap_data[k];
          nrd++;
        end
        nb++;
      end
      @(posedge clk);
      #1;
      data_i  = (nb < 16) ? wd[nb] : 32'd0;
      clear_i = (clr_at > 0) && (nb == clr_at) && cap_v[k];
    end
    clear_i = 1'b0;
  endtask

  // Expected handshake per cycle as {valid, done, exception, ready}.
  task automatic check_txn(input string tag, input int lat, input int n,
                           input bit err, input int ncyc);
    int dc;
    logic [3:0] exp;
    dc = err ? 1 : lat + n + 1;
    for (int k = 0; k <= ncyc; k++) begin
      exp[3] = !err && (k >= lat + 1) && (k <= lat + n);
      exp[2] = (k == dc);
      exp[1] = err && (k == dc);
      exp[0] = (k == 0) || (k > dc);
      chk($sformatf("%s_c%0d", tag, k), {32'd0, cap_v[k], cap_d[k], cap_e[k], cap_r[k]},
          {32'd0, exp});
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    nrd         = 0;
    resetn_i    = 1'b0;
    reqdev_i    = 3'd0;
    req_i       = 1'b0;
    req_block_i = 1'b0;
    rw_i        = 1'b0;
    add_i       = 27'd0;
    data_i      = 32'd0;
    clear_i     = 1'b0;
    for (int i = 0; i < 16; i++) wd[i] = 32'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_flags2", {ready2, valid2, done2, exc2}, 4'b0000);
    chk("rst_data2", data2, 32'd0);
    chk("rst_flags0", {ready0, valid0, done0, exc0}, 4'b0000);
    @(posedge clk);
    #1 resetn_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready2", ready2, 1'b1);
    chk("rst_ready0", ready0, 1'b1);
    @(posedge clk);
    #1;

    // Single write then read, LATENCY 2
    wd[0] = 32'hDEADBEEF;
    run_txn(1'b0, 1'b1, 1'b0, 27'h10, 6, 0);
    check_txn("wr1", 2, 1, 1'b0, 6);
    run_txn(1'b0, 1'b0, 1'b0, 27'h10, 6, 0);
    check_txn("rd1", 2, 1, 1'b0, 6);
    chk("rd1_n", nrd, 1);
    chk("rd1_data", cap_data[3], 32'hDEADBEEF);

    // Block write at 0x2C lands on words 8..11
    for (int i = 0; i < 4; i++) wd[i] = 32'hA0 + i;
    run_txn(1'b0, 1'b1, 1'b1, 27'h2C, 8, 0);
    check_txn("bwr", 2, 4, 1'b0, 8);
    run_txn(1'b0, 1'b0, 1'b1, 27'h2C, 8, 0);
    check_txn("brd", 2, 4, 1'b0, 8);
    chk("brd_n", nrd, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("brd_d%0d", i), cap_rd[i], 32'hA0 + i);
    run_txn(1'b0, 1'b0, 1'b0, 27'h28, 6, 0);
    chk("rd_w10", cap_data[3], 32'hA2);

    // Address errors leave memory untouched
    wd[0] = 32'h11111111;
    run_txn(1'b0, 1'b1, 1'b0, 27'h0, 6, 0);
    wd[0] = 32'h00000BAD;
    run_txn(1'b0, 1'b1, 1'b0, 27'h3, 2, 0);
    check_txn("err_lo", 0, 1, 1'b1, 2);
    run_txn(1'b0, 1'b1, 1'b1, 27'h400_0000, 2, 0);
    check_txn("err_hi", 0, 1, 1'b1, 2);
    run_txn(1'b0, 1'b0, 1'b0, 27'h0, 6, 0);
    chk("err_mem", cap_data[3], 32'h11111111);

    // Device filter
    reqdev_i = 3'd5;
    req_i    = 1'b1;
    rw_i     = 1'b0;
    add_i    = 27'h10;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("devf_c%0d", k), {valid2, done2, exc2, ready2}, 4'b0001);
      @(posedge clk);
      #1;
    end
    req_i    = 1'b0;
    reqdev_i = 3'd0;
    @(posedge clk);
    #1;

    // Backpressure: request held high through a whole transfer
    req_i       = 1'b1;
    rw_i        = 1'b0;
    req_block_i = 1'b0;
    add_i       = 27'h10;
    for (int k = 0; k <= 10; k++) begin
      logic [3:0] exp;
      if (k == 10) begin
        req_i = 1'b0;
      end
      @(negedge clk);
      exp[3] = (k == 3) || (k == 8);
      exp[2] = (k == 4) || (k == 9);
      exp[1] = 1'b0;
      exp[0] = (k == 0) || (k == 5) || (k == 10);
      chk($sformatf("bp_c%0d", k), {valid2, done2, exc2, ready2}, exp);
      if (exp[3]) chk($sformatf("bp_d%0d", k), data2, 32'hDEADBEEF);
      @(posedge clk);
      #1;
    end
    repeat (4) @(posedge clk);
    #1;

    // Clear during the second beat of a block write
    for (int i = 0; i < 4; i++) wd[i] = 32'hB0 + i;
    run_txn(1'b0, 1'b1, 1'b1, 27'h20, 7, 1);
    for (int k = 0; k <= 7; k++) begin
      logic [3:0] exp;
      exp[3] = (k == 3) || (k == 4);
      exp[2] = 1'b0;
      exp[1] = 1'b0;
      exp[0] = (k == 0) || (k >= 5);
      chk($sformatf("clr_c%0d", k), {32'd0, cap_v[k], cap_d[k], cap_e[k], cap_r[k]},
          {32'd0, exp});
    end
    run_txn(1'b0, 1'b0, 1'b1, 27'h20, 8, 0);
    chk("clr_rd0", cap_rd[0], 32'hB0);
    chk("clr_rd1", cap_rd[1], 32'hB1);
    chk("clr_rd2", cap_rd[2], 32'hA2);
    chk("clr_rd3", cap_rd[3], 32'hA3);

    repeat (8) @(posedge clk);
    #1;

    // LATENCY 0 instance
    wd[0] = 32'hCAFEF00D;
    run_txn(1'b1, 1'b1, 1'b0, 27'h44, 3, 0);
    check_txn("l0_wr", 0, 1, 1'b0, 3);
    run_txn(1'b1, 1'b0, 1'b0, 27'h44, 3, 0);
    check_txn("l0_rd", 0, 1, 1'b0, 3);
    chk("l0_rd_d", cap_data[1], 32'hCAFEF00D);
    for (int i = 0; i < 4; i++) wd[i] = 32'hC0 + i;
    run_txn(1'b1, 1'b1, 1'b1, 27'h40, 6, 0);
    check_txn("l0_bwr", 0, 4, 1'b0, 6);
    repeat (8) @(posedge clk);
    #1;

    // Reset in the middle of a block read
    reqdev_i    = 3'd0;
    req_i       = 1'b1;
    rw_i        = 1'b0;
    req_block_i = 1'b1;
    add_i       = 27'h40;
    @(negedge clk);
    chk("mr_c0", ready0, 1'b1);
    @(posedge clk);
    #1 req_i = 1'b0;
    @(negedge clk);
    chk("mr_c1", {valid0, data0}, {1'b1, 32'hC0});
    @(posedge clk);
    #1 resetn_i = 1'b0;
    @(negedge clk);
    chk("mr_c2", {valid0, data0}, {1'b1, 32'hC1});
    @(posedge clk);
    #1 resetn_i = 1'b1;
    @(negedge clk);
    chk("mr_c3", {ready0, valid0, done0, exc0, data0}, 36'd0);
    @(posedge clk);
    @(negedge clk);
    chk("mr_c4", {ready0, valid0, done0}, 3'b100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
